// File: rtl/l2_mem_pkg.sv
// Shared types and sizing helpers for the L2 backing-memory responder.
// Sizing localparams reflect the default configuration; modules derive their own from parameters.
package l2_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_BLOCK_SIZE = 8;

  localparam int OFFSET_BITS = $clog2(DEF_BLOCK_SIZE);
  localparam int INDEX_BITS  = DEF_ADDR_WIDTH - OFFSET_BITS;
  localparam int NUM_BLOCKS  = 1 << INDEX_BITS;
  localparam int BLOCK_BITS  = DEF_BLOCK_SIZE * DEF_DATA_WIDTH;

  // Counter only ever holds LAT-1, so clog2 of the larger latency suffices (min 1 bit).
  function automatic int cnt_width(input int rd_lat, input int wr_lat);
    int max_lat;
    max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return (max_lat <= 2) ? 1 : $clog2(max_lat);
  endfunction

endpackage

// File: rtl/l2_backing_mem_if.sv
// L2 memory-side bus: block address, read/write request levels, block data and completion status.
interface l2_backing_mem_if
  import l2_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BLOCK_SIZE = DEF_BLOCK_SIZE
);

  localparam int BLK_W = BLOCK_SIZE * DATA_WIDTH;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_read;
  logic                  mem_write;
  logic [BLK_W-1:0]      mem_data_out_flat;
  logic [BLK_W-1:0]      mem_data_block_flat;
  logic                  mem_ready;
  logic                  mem_busy;
  logic                  proto_err;

  modport master (
    output mem_addr, mem_read, mem_write, mem_data_out_flat,
    input  mem_data_block_flat, mem_ready, mem_busy, proto_err
  );

  modport slave (
    input  mem_addr, mem_read, mem_write, mem_data_out_flat,
    output mem_data_block_flat, mem_ready, mem_busy, proto_err
  );

endinterface

// File: rtl/l2_mem_array.sv
// Single-port block RAM: synchronous write, registered read, synchronous clear of every entry.
// The read register only changes on a read strobe or clear, so it doubles as the held read block.
module l2_mem_array
  import l2_mem_pkg::*;
#(
  parameter int IDX_W = INDEX_BITS,
  parameter int BLK_W = BLOCK_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [BLK_W-1:0] wdata_i,
  output logic [BLK_W-1:0] rdata_o
);

  localparam int N_BLK = 1 << IDX_W;

  logic [BLK_W-1:0] mem_q [N_BLK];
  logic [BLK_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BLK; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[idx_i] <= wdata_i;
      end
      if (re_i) begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/l2_backing_mem.sv
// Main-memory responder for the L2 memory side: whole-block reads/writes with programmable latency.
// state | meaning
// IDLE  | waiting; request levels sampled, write wins over read (and flags proto_err)
// BUSY  | latency countdown; at zero the write commits or the read block is loaded
// RESP  | one-cycle mem_ready pulse, then back to IDLE
module l2_backing_mem
  import l2_mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int BLOCK_SIZE    = 8,
  parameter int READ_LATENCY  = 3,
  parameter int WRITE_LATENCY = 2
) (
  input logic               clk,
  input logic               rst,
  l2_backing_mem_if.slave   mem_if
);

  localparam int OFF_W = $clog2(BLOCK_SIZE);
  localparam int IDX_W = ADDR_WIDTH - OFF_W;
  localparam int BLK_W = BLOCK_SIZE * DATA_WIDTH;
  localparam int CNT_W = cnt_width(READ_LATENCY, WRITE_LATENCY);

  localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_INIT = CNT_W'(WRITE_LATENCY - 1);

  state_e           state_q;
  op_e              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [BLK_W-1:0] wdata_q;
  logic             ready_q;
  logic             busy_q;
  logic             perr_q;

  logic [IDX_W-1:0] req_idx;
  logic             commit;
  logic             arr_we;
  logic             arr_re;
  logic [BLK_W-1:0] arr_rdata;

  assign req_idx = mem_if.mem_addr[ADDR_WIDTH-1:OFF_W];

  if (OFF_W > 0) begin : g_offset
    logic unused_offset;
    assign unused_offset = ^mem_if.mem_addr[OFF_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_RD;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          if (mem_if.mem_write) begin
            idx_q   <= req_idx;
            wdata_q <= mem_if.mem_data_out_flat;
            op_q    <= OP_WR;
            cnt_q   <= WR_INIT;
            busy_q  <= 1'b1;
            state_q <= BUSY;
            if (mem_if.mem_read) begin
              perr_q <= 1'b1;
            end
          end else if (mem_if.mem_read) begin
            idx_q   <= req_idx;
            op_q    <= OP_RD;
            cnt_q   <= RD_INIT;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            ready_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Array access happens on the same edge that leaves BUSY, so RESP already sees the result.
  assign commit = (state_q == BUSY) && (cnt_q == '0);
  assign arr_we = commit && (op_q == OP_WR);
  assign arr_re = commit && (op_q == OP_RD);

  l2_mem_array #(
    .IDX_W (IDX_W),
    .BLK_W (BLK_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  assign mem_if.mem_data_block_flat = arr_rdata;
  assign mem_if.mem_ready           = ready_q;
  assign mem_if.mem_busy            = busy_q;
  assign mem_if.proto_err           = perr_q;

endmodule
